ov5640_config: RTL and testbench
================================

# ov5640_config

Power-up configuration master for the OV5640 camera sensor. After reset it waits for sensor power-up, writes a fixed register table over SCCB (I2C-compatible, 16-bit register address), then reads back the chip-ID high byte. It asserts `cfg_done` when finished. It sits between the system clock domain and the sensor's SIO_C/SIO_D pins.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, sysclk frequency in Hz.
- `SCL_FREQ`, 250_000, SCCB clock frequency in Hz; quarter-bit divider `DIV = CLK_FREQ/(4*SCL_FREQ)` (100 by default).
- `PWR_DLY`, 20_000, sysclk cycles of idle after reset before the first transaction.
- `RST_DLY`, 20_000, sysclk cycles of idle after the soft-reset write (entry 1).
- `DEV_ADDR`, 8'h78, SCCB write address; read address is `DEV_ADDR|1` (8'h79).

Ports:
- `sysclk` in 1: system clock, all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-high (asserted when 1).
- `cmos_sclk` out 1: SCCB clock.
- `cmos_sdat` inout 1: SCCB data. Push-pull when the master drives; high-Z during ACK slots and read data bits.
- `cfg_done` out 1: configuration and ID read complete; sticky.
- `rd_data` out 8: byte read from register 0x300A.

## Operation
- Register table, written in index order as {addr16, data8}:
  - 0: 3103=11
  - 1: 3008=82 (soft reset)
  - 2: 3008=42
  - 3: 3017=FF
  - 4: 3018=FF
  - 5: 3034=1A
  - 6: 3035=11
  - 7: 3008=02
- FSM states: IDLE_DLY → WRITE (entries 0..7) → READ → DONE.
  - IDLE_DLY lasts `PWR_DLY` cycles.
  - After entry 1 completes, wait `RST_DLY` cycles, then continue with entry 2.
  - Between any two transactions, keep the bus idle for at least one bit time.
- Write transaction (3-phase): START, DEV_ADDR, X, addrH, X, addrL, X, data, X, STOP.
  - X is the 9th-bit ACK slot. The master releases SDA and ignores the value.
- Read (2-phase write followed by 2-phase read):
  - First: START, 0x78, X, 0x30, X, 0x0A, X, STOP, then idle for one bit time.
  - Second: START, 0x79, X, 8 data bits, NA (master drives 1), STOP.
- Bytes are sent MSB first.
- Read data bits are sampled at mid-high of SCL, MSB first. A Z or X value samples as 1.
- `rd_data` is loaded at the read STOP. `cfg_done` rises in the same cycle and stays 1 until reset.
- Once in DONE, the bus stays idle (SCL=1, SDA driven 1).
- Reset asserted at any time:
  - Aborts the current transfer immediately.
  - Outputs return to reset values.
  - After release, the sequence restarts from IDLE_DLY at entry 0.

## Timing
- Reset values: `cmos_sclk`=1, `cmos_sdat` driven 1, `cfg_done`=0, `rd_data`=8'h00.
- One bit time = 4 quarters of `DIV` cycles each.
- Data bit:
  - Q0: SCL low; SDA is updated at the start of Q0.
  - Q1: SCL low.
  - Q2 and Q3: SCL high.
  - Read data is sampled on the last cycle of Q2.
- START (one bit time): SDA=1 and SCL=1 for Q0–Q1, SDA falls at Q2, SCL falls at the end of Q3.
- STOP (one bit time): SDA=0 with SCL low for Q0, SCL rises at Q1, SDA rises at Q2.
- Write transaction = START + 36 bits + STOP = 38 bit times = 152·DIV cycles.
- The first START begins `PWR_DLY` cycles (±2) after reset release.
- No back-pressure and no handshake. The sequence is free-running.

## Test plan
- Reset held at 1: `cmos_sclk`=1, `cmos_sdat`=1, `cfg_done`=0, `rd_data`=00 throughout. Releasing reset mid-transaction returns the bus to idle within 1 cycle.
- Run with DIV=4, PWR_DLY=RST_DLY=100:
  - The first START appears about 100 cycles after reset release.
  - A bus monitor decodes the write sequence 78/31/03/11, 78/30/08/82, and so on, through 78/30/08/02 in table order.
  - The gap between entry 1 and entry 2 is at least 100 cycles.
- Bus sanity: SDA never changes while SCL is high, except at START/STOP. Each write transaction spans 152·DIV cycles.
- Sensor model drives 0x56 during the read data bits:
  - The bench sees address phase 78/30/0A, then 79 followed by NA.
  - `rd_data`=8'h56 and `cfg_done`=1 after the final STOP.
- No sensor model attached (SDA floating in read slots): `rd_data`=8'hFF, `cfg_done`=1, and no hang.
- Reset pulse after `cfg_done`: `cfg_done` returns to 0 and the full sequence repeats identically.

Source files
------------

// File: rtl/ov5640_config.sv
// Power-up configuration master for the OV5640: waits for sensor power-up, writes a fixed
// register table over SCCB and then reads back the chip-ID high byte (0x300A).
module ov5640_config #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned SCL_FREQ = 250_000,
   parameter int unsigned PWR_DLY  = 20_000,
   parameter int unsigned RST_DLY  = 20_000,
   parameter logic [7:0]  DEV_ADDR = 8'h78
) (
   input  logic       sysclk,
   input  logic       rst_n,
   output logic       cmos_sclk,
   inout  wire        cmos_sdat,
   output logic       cfg_done,
   output logic [7:0] rd_data
);

   localparam int unsigned DIV     = CLK_FREQ / (4 * SCL_FREQ);
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned DLY_MAX = (PWR_DLY > RST_DLY) ? PWR_DLY : RST_DLY;
   localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

   typedef enum logic [2:0] {
      StIdleDly, StWrite, StRstDly, StRdAddr, StRdData, StDone
   } state_e;

   typedef enum logic [2:0] {
      BsIdle, BsStart, BsBits, BsStop, BsGap
   } bus_e;

   state_e           state_q, state_d;
   bus_e             bus_q, bus_d;
   logic [2:0]       entry_q, entry_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]       quarter_q, quarter_d;
   logic [3:0]       bit_q, bit_d;
   logic [1:0]       byte_q, byte_d;
   logic [31:0]      shift_q, shift_d;
   logic [7:0]       rx_q, rx_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             cfg_done_q, cfg_done_d;
   logic             scl_q, scl_d, sda_q, sda_d, sda_oe_q, sda_oe_d;
   logic             go, is_rd, quarter_end, bit_end, rd_byte, xfer_done, sda_in;
   logic [1:0]       last_byte;
   logic [31:0]      tx_frame;

   function automatic logic [23:0] table_entry(input logic [2:0] idx);
      case (idx)
         3'd0:    table_entry = 24'h3103_11;
         3'd1:    table_entry = 24'h3008_82;
         3'd2:    table_entry = 24'h3008_42;
         3'd3:    table_entry = 24'h3017_FF;
         3'd4:    table_entry = 24'h3018_FF;
         3'd5:    table_entry = 24'h3034_1A;
         3'd6:    table_entry = 24'h3035_11;
         default: table_entry = 24'h3008_02;
      endcase
   endfunction

   assign quarter_end = (div_cnt_q == DIV_W'(DIV - 1));
   assign bit_end     = quarter_end && (quarter_q == 2'd3);
   assign xfer_done   = (bus_q == BsGap) && bit_end;
   assign rd_byte     = is_rd && (byte_q == 2'd1);

   // An undriven line (Z/X) must read as 1, as the bus pull-up would make it.
   always_comb begin
      case (cmos_sdat)
         1'b0:    sda_in = 1'b0;
         default: sda_in = 1'b1;
      endcase
   end

   // Sequencer: power-up delay, table writes, chip-ID read.
   always_comb begin
      state_d   = state_q;
      entry_d   = entry_q;
      dly_d     = dly_q;
      go        = 1'b0;
      is_rd     = 1'b0;
      last_byte = 2'd3;
      tx_frame  = {DEV_ADDR, table_entry(entry_q)};
      unique case (state_q)
         StIdleDly: begin
            if (dly_q == DLY_W'(PWR_DLY - 1)) begin
               state_d = StWrite;
               dly_d   = '0;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         StWrite: begin
            go = 1'b1;
            if (xfer_done) begin
               entry_d = entry_q + 3'd1;
               if (entry_q == 3'd7) begin
                  state_d = StRdAddr;
               end else if (entry_q == 3'd1) begin
                  state_d = StRstDly;
               end
            end
         end
         StRstDly: begin
            if (dly_q == DLY_W'(RST_DLY - 1)) begin
               state_d = StWrite;
               dly_d   = '0;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         StRdAddr: begin
            go        = 1'b1;
            last_byte = 2'd2;
            tx_frame  = {DEV_ADDR, 8'h30, 8'h0A, 8'h00};
            if (xfer_done) begin
               state_d = StRdData;
            end
         end
         StRdData: begin
            go        = 1'b1;
            is_rd     = 1'b1;
            last_byte = 2'd1;
            tx_frame  = {DEV_ADDR | 8'h01, 24'h00_0000};
            if (xfer_done) begin
               state_d = StDone;
            end
         end
         StDone: ;
         default: state_d = StIdleDly;
      endcase
   end

   // Bit engine: each slot is four quarters of DIV cycles; a gap slot follows every STOP.
   always_comb begin
      bus_d      = bus_q;
      div_cnt_d  = div_cnt_q;
      quarter_d  = quarter_q;
      bit_d      = bit_q;
      byte_d     = byte_q;
      shift_d    = shift_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      cfg_done_d = cfg_done_q;
      scl_d      = 1'b1;
      sda_d      = 1'b1;
      sda_oe_d   = 1'b1;
      if (bus_q != BsIdle) begin
         div_cnt_d = quarter_end ? '0 : div_cnt_q + DIV_W'(1);
         if (quarter_end) begin
            quarter_d = quarter_q + 2'd1;
         end
      end
      unique case (bus_q)
         BsIdle: begin
            if (go) begin
               bus_d   = BsStart;
               shift_d = tx_frame;
               byte_d  = '0;
               bit_d   = '0;
            end
         end
         BsStart: begin
            sda_d = ~quarter_q[1];
            if (bit_end) begin
               bus_d = BsBits;
            end
         end
         BsBits: begin
            scl_d = quarter_q[1];
            if (bit_q == 4'd8) begin
               // ACK slot is released; after the read byte the master drives NA (1).
               sda_oe_d = rd_byte;
               sda_d    = 1'b1;
            end else begin
               sda_oe_d = ~rd_byte;
               sda_d    = shift_q[31];
            end
            // Outputs are registered, so the pin is in its last Q2 cycle here.
            if (rd_byte && (bit_q != 4'd8) && (quarter_q == 2'd3) && (div_cnt_q == '0)) begin
               rx_d = {rx_q[6:0], sda_in};
            end
            if (bit_end) begin
               if (bit_q == 4'd8) begin
                  bit_d = '0;
                  if (byte_q == last_byte) begin
                     bus_d = BsStop;
                  end else begin
                     byte_d = byte_q + 2'd1;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  shift_d = {shift_q[30:0], 1'b0};
               end
            end
         end
         BsStop: begin
            scl_d = (quarter_q != 2'd0);
            sda_d = quarter_q[1];
            if (bit_end) begin
               bus_d = BsGap;
               if (is_rd) begin
                  rd_data_d  = rx_q;
                  cfg_done_d = 1'b1;
               end
            end
         end
         BsGap: begin
            if (bit_end) begin
               bus_d = BsIdle;
            end
         end
         default: bus_d = BsIdle;
      endcase
   end

   always_ff @(posedge sysclk or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= StIdleDly;
         bus_q      <= BsIdle;
         entry_q    <= '0;
         dly_q      <= '0;
         div_cnt_q  <= '0;
         quarter_q  <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         cfg_done_q <= 1'b0;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
         sda_oe_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         bus_q      <= bus_d;
         entry_q    <= entry_d;
         dly_q      <= dly_d;
         div_cnt_q  <= div_cnt_d;
         quarter_q  <= quarter_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         cfg_done_q <= cfg_done_d;
         scl_q      <= scl_d;
         sda_q      <= sda_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   assign cmos_sclk = scl_q;
   assign cmos_sdat = sda_oe_q ? sda_q : 1'bz;
   assign cfg_done  = cfg_done_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_ov5640_config.sv
// Directed bench for ov5640_config: SCCB bus monitor, optional read-data sensor model,
// and a linear sequence of reset, full-run, reset-after-done and abort checks.
module tb_ov5640_config;

   localparam int unsigned CLK_FREQ = 4_000_000;
   localparam int unsigned SCL_FREQ = 250_000;
   localparam int unsigned DIV      = 4;
   localparam int unsigned PWR_DLY  = 100;
   localparam int unsigned RST_DLY  = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   wire        sda;
   logic       sclk;
   logic       cfg_done;
   logic [7:0] rd_data;
   logic       sens_low = 1'b0;
   logic       sens_en  = 1'b0;

   assign sda = sens_low ? 1'b0 : 1'bz;
   pullup (sda);

   ov5640_config #(
      .CLK_FREQ (CLK_FREQ),
      .SCL_FREQ (SCL_FREQ),
      .PWR_DLY  (PWR_DLY),
      .RST_DLY  (RST_DLY),
      .DEV_ADDR (8'h78)
   ) dut (
      .sysclk    (clk),
      .rst_n     (rst),
      .cmos_sclk (sclk),
      .cmos_sdat (sda),
      .cfg_done  (cfg_done),
      .rd_data   (rd_data)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected write/address bytes in bus order; the read byte is checked separately.
   logic [7:0] exp_bytes [36] = '{
      8'h78, 8'h31, 8'h03, 8'h11,  8'h78, 8'h30, 8'h08, 8'h82,
      8'h78, 8'h30, 8'h08, 8'h42,  8'h78, 8'h30, 8'h17, 8'hFF,
      8'h78, 8'h30, 8'h18, 8'hFF,  8'h78, 8'h30, 8'h34, 8'h1A,
      8'h78, 8'h30, 8'h35, 8'h11,  8'h78, 8'h30, 8'h08, 8'h02,
      8'h78, 8'h30, 8'h0A, 8'h79
   };

   // Bus monitor and sensor model
   int         start_t[$];
   int         stop_t[$];
   logic [7:0] mon_bytes[$];
   int         glitches = 0;
   logic       scl_p = 1'b1;
   logic       sda_p = 1'b1;
   int         bitk = 0;
   int         nbyte = 0;
   int         sens_idx = 0;
   logic       sens_arm = 1'b0;
   logic       sens_act = 1'b0;
   logic [7:0] sh = 8'h00;
   logic [7:0] sens_data = 8'h56;

   always @(negedge clk) begin
      if (rst) begin
         bitk     = 0;
         nbyte    = 0;
         sens_arm = 1'b0;
         sens_act = 1'b0;
         sens_low = 1'b0;
      end else if (scl_p && sclk && sda_p && !sda) begin
         if (bitk != 0) glitches++;
         start_t.push_back(cyc);
         bitk  = 0;
         nbyte = 0;
      end else if (scl_p && sclk && !sda_p && sda) begin
         // the STOP's own SCL rise counts as one phantom bit
         if (bitk != 1) glitches++;
         stop_t.push_back(cyc);
         bitk = 0;
      end else if (!scl_p && sclk) begin
         if (bitk < 8) begin
            sh = {sh[6:0], sda};
            bitk++;
            if (bitk == 8) begin
               mon_bytes.push_back(sh);
               if (nbyte == 0 && sh == 8'h79 && sens_en) sens_arm = 1'b1;
               nbyte++;
            end
         end else begin
            bitk = 0;
         end
      end else if (scl_p && !sclk) begin
         if (sens_act) begin
            if (sens_idx >= 0) begin
               sens_low = !sens_data[sens_idx];
               sens_idx--;
            end else begin
               sens_low = 1'b0;
               sens_act = 1'b0;
            end
         end else if (sens_arm) begin
            sens_arm = 1'b0;
            sens_act = 1'b1;
            sens_idx = 7;
         end
      end
      scl_p = sclk;
      sda_p = sda;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      n_tests++;
      assert (obs >= lo && obs <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!cfg_done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", 32'(cfg_done), 32'd1);
      repeat (4 * DIV) @(negedge clk);
   endtask

   task automatic check_run(input logic [7:0] exp_rd, input int rel);
      check("rd_data", 32'(rd_data), 32'(exp_rd));
      check("cfg_done", 32'(cfg_done), 32'd1);
      check("n_start", 32'(start_t.size()), 32'd10);
      check("n_stop", 32'(stop_t.size()), 32'd10);
      check("n_bytes", 32'(mon_bytes.size()), 32'd37);
      check("glitches", 32'(glitches), 32'd0);
      if (start_t.size() >= 10 && stop_t.size() >= 10 && mon_bytes.size() >= 37) begin
         // SDA falls two quarters into the first START slot
         check_range("first_start", start_t[0] - rel, PWR_DLY + 2 * DIV - 2,
                     PWR_DLY + 2 * DIV + 2);
         for (int i = 0; i < 36; i++) check($sformatf("byte%0d", i), 32'(mon_bytes[i]),
                                            32'(exp_bytes[i]));
         check("byte_rd", 32'(mon_bytes[36]), 32'(exp_rd));
         // START SDA fall to STOP SDA rise: 37 bit times
         for (int i = 0; i < 8; i++) check($sformatf("span%0d", i), 32'(stop_t[i] - start_t[i]),
                                           32'(148 * DIV));
         check_range("gap01", start_t[1] - stop_t[0], 4 * DIV, RST_DLY - 1);
         check_range("gap12", start_t[2] - stop_t[1], RST_DLY, RST_DLY + 16 * DIV);
         check_range("gap78", start_t[8] - stop_t[7], 4 * DIV, RST_DLY - 1);
         check_range("gap89", start_t[9] - stop_t[8], 4 * DIV, RST_DLY - 1);
      end
   endtask

   task automatic clear_monitor();
      start_t.delete();
      stop_t.delete();
      mon_bytes.delete();
   endtask

   int rel;

   initial begin
      rst     = 1'b1;
      sens_en = 1'b1;
      repeat (20) @(negedge clk);
      check("rst_sclk", 32'(sclk), 32'd1);
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_done", 32'(cfg_done), 32'd0);
      check("rst_rd", 32'(rd_data), 32'd0);

      // Run 1: sensor answers 0x56
      @(negedge clk);
      rst = 1'b0;
      rel = cyc;
      wait_done();
      check_run(8'h56, rel);
      repeat (50) @(negedge clk);
      check("done_sclk", 32'(sclk), 32'd1);
      check("done_sda", 32'(sda), 32'd1);
      check("done_sticky", 32'(cfg_done), 32'd1);

      // Reset pulse after cfg_done
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst2_done", 32'(cfg_done), 32'd0);
      check("rst2_rd", 32'(rd_data), 32'd0);
      check("rst2_sclk", 32'(sclk), 32'd1);
      check("rst2_sda", 32'(sda), 32'd1);
      repeat (5) @(negedge clk);
      clear_monitor();

      // Abort in the middle of the first write
      rst = 1'b0;
      @(negedge clk);
      check("rel_idle_sclk", 32'(sclk), 32'd1);
      check("rel_idle_sda", 32'(sda), 32'd1);
      repeat (PWR_DLY + 300) @(negedge clk);
      check("mid_starts", 32'(start_t.size()), 32'd1);
      check("mid_stops", 32'(stop_t.size()), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_sclk", 32'(sclk), 32'd1);
      check("abort_sda", 32'(sda), 32'd1);
      check("abort_done", 32'(cfg_done), 32'd0);
      repeat (5) @(negedge clk);
      clear_monitor();

      // Run 2: no sensor, read slots float high
      sens_en = 1'b0;
      rst     = 1'b0;
      rel     = cyc;
      wait_done();
      check_run(8'hFF, rel);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
